// File: rtl/pp_fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package pp_fetch_pkg;

    localparam int INSTR_W = 32;
    localparam int ADDR_W  = 32;

    // Word addressing: consecutive instructions differ by one.
    localparam logic [ADDR_W-1:0] PC_STEP = 32'd1;

    typedef enum logic [1:0] {
        RESET_S = 2'd0,
        FETCH   = 2'd1,
        DROP    = 2'd2
    } fetch_state_t;

    // One queue slot: the PC travels with its instruction into IF/ID.
    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/sync_fifo_pp.sv
// Small synchronous FIFO of {pc, instr} entries with flush and a
// combinational head read. Callers guarantee no push when full and no pop
// when empty.
module sync_fifo_pp
    import pp_fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  fetch_entry_t                 push_data,
    input  logic                         pop,
    input  logic                         flush,
    output fetch_entry_t                 head,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    fetch_entry_t  mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;

    assign head = mem[rd_ptr];

    // Storage write port; cleared on reset.
    always_ff @(posedge clk) begin
        // NOTE: the storage array is reset on purpose so the head reads as zero straight after reset.
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (push && !flush) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers and occupancy; flush empties the queue and wins over push/pop.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register here sees the pre-edge values of the others.
        if (rst || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fetch_queue_pp.sv
// Instruction-fetch front end: issues word-addressed requests to a
// variable-latency instruction memory, queues returned instructions with
// their PC, and hands them to IF/ID over valid/ready. A redirect flushes
// the queue and discards responses still in flight for the old stream.
module fetch_queue_pp
    import pp_fetch_pkg::*;
#(
    parameter int                DEPTH           = 4,
    parameter int                MAX_OUTSTANDING = 2,
    parameter logic [ADDR_W-1:0] RESET_PC        = 32'h0000_0000
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         redirect,
    input  logic [ADDR_W-1:0]            redirect_pc,
    output logic                         imem_req_valid,
    input  logic                         imem_req_ready,
    output logic [ADDR_W-1:0]            imem_req_addr,
    input  logic                         imem_resp_valid,
    input  logic [INSTR_W-1:0]           imem_resp_instr,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [ADDR_W-1:0]            out_pc,
    output logic [INSTR_W-1:0]           out_instr,
    output logic [$clog2(DEPTH+1)-1:0]   queue_count
);

    localparam int          OW        = $clog2(MAX_OUTSTANDING+1);
    localparam logic [31:0] DEPTH_U   = DEPTH;
    localparam logic [31:0] MAX_OUT_U = MAX_OUTSTANDING;

    fetch_state_t      state;
    fetch_state_t      state_next;
    logic [ADDR_W-1:0] fetch_pc;
    logic [ADDR_W-1:0] resp_pc;
    logic [OW-1:0]     out_total;
    logic [OW-1:0]     drop_cnt;
    logic [OW-1:0]     drop_cnt_next;
    logic              req_fire;
    logic              resp_keep;
    fetch_entry_t      push_data;
    fetch_entry_t      head;

    assign req_fire      = imem_req_valid && imem_req_ready;
    // Stale responses are consumed by count; the redirect cycle drops its own.
    assign resp_keep     = imem_resp_valid && !redirect && (drop_cnt == '0);
    assign imem_req_addr = fetch_pc;
    assign push_data     = '{pc: resp_pc, instr: imem_resp_instr};
    assign out_pc        = head.pc;
    assign out_instr     = head.instr;

    sync_fifo_pp #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (resp_keep),
        .push_data (push_data),
        .pop       (out_valid && out_ready),
        .flush     (redirect),
        .head      (head),
        .count     (queue_count)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= RESET_S;
        else     state <= state_next;
    end

    // Next state: leave reset once, then track whether stale responses remain.
    always_comb begin
        // NOTE: default first so every path assigns state_next and no latch is inferred.
        state_next = state;
        case (state)
            RESET_S: state_next = FETCH;
            FETCH:   if (redirect && drop_cnt_next != '0) state_next = DROP;
            DROP:    if (drop_cnt_next == '0) state_next = FETCH;
            default: state_next = RESET_S;
        endcase
    end

    // Outputs: credit-limited request issue and head-valid toward IF/ID.
    always_comb begin
        imem_req_valid = (state != RESET_S) && !redirect
                      && (32'(out_total) < MAX_OUT_U)
                      && (32'(queue_count) + 32'(out_total) < DEPTH_U);
        out_valid      = (queue_count != '0) && !redirect;
    end

    // Discard count: a redirect marks everything still outstanding as stale.
    always_comb begin
        drop_cnt_next = drop_cnt;
        if (redirect) begin
            drop_cnt_next = out_total - OW'(imem_resp_valid);
        end else if (imem_resp_valid && drop_cnt != '0) begin
            drop_cnt_next = drop_cnt - OW'(1);
        end
    end

    // Fetch/response PCs and in-flight bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc  <= RESET_PC;
            resp_pc   <= RESET_PC;
            out_total <= '0;
            drop_cnt  <= '0;
        end else begin
            out_total <= out_total + OW'(req_fire) - OW'(imem_resp_valid);
            drop_cnt  <= drop_cnt_next;
            if (redirect) begin
                fetch_pc <= redirect_pc;
                resp_pc  <= redirect_pc;
            end else begin
                if (req_fire)  fetch_pc <= fetch_pc + PC_STEP;
                if (resp_keep) resp_pc  <= resp_pc + PC_STEP;
            end
        end
    end

endmodule

// File: tb/tb_fetch_queue_pp.sv
// Self-checking bench for fetch_queue_pp: a reset/startup vector table,
// directed multi-cycle sequences, and a randomized run against a
// behavioural model built from request/response queues tagged by stream.
module tb_fetch_queue_pp;

    localparam int          DEPTH    = 4;
    localparam int          MAX_OUT  = 2;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid = 1'b0;
    logic [31:0] imem_resp_instr = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic [2:0]  queue_count;

    fetch_queue_pp #(.DEPTH(DEPTH), .MAX_OUTSTANDING(MAX_OUT), .RESET_PC(RESET_PC)) dut (
        .clk             (clk),
        .rst             (rst),
        .redirect        (redirect),
        .redirect_pc     (redirect_pc),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_instr (imem_resp_instr),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_pc          (out_pc),
        .out_instr       (out_instr),
        .queue_count     (queue_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr_dut;
        logic [31:0] addr_exp;
        int          epoch;
        int          due;
    } mem_req_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    typedef struct {
        bit          chk;
        bit          rst;
        bit          out_ready;
        bit          exp_req_valid;
        logic [31:0] exp_addr;
        bit          exp_out_valid;
        logic [31:0] exp_out_pc;
        int          exp_count;
    } vec_t;

    mem_req_t    mem_q[$];
    exp_t        exp_q[$];

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          epoch = 0;
    int          last_due = 0;
    int          lat = 1;
    logic [31:0] m_fetch_pc = RESET_PC;
    bit          armed = 1'b0;
    bit          rst_prev = 1'b0;

    bit          d_rst = 1'b1;
    bit          d_redirect = 1'b0;
    logic [31:0] d_redirect_pc = '0;
    bit          d_out_ready = 1'b0;
    bit          d_req_ready = 1'b1;

    logic        s_req_valid;
    logic [31:0] s_addr;
    logic        s_out_valid;
    logic [31:0] s_pc;
    logic [31:0] s_instr;
    logic [31:0] s_count;
    bit          s_popped;
    logic [31:0] s_pop_pc;
    logic [31:0] s_pop_instr;

    vec_t        vecs[9];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock cycle: drive inputs and memory response at the falling edge,
    // sample and compare against the model, then advance the model.
    task automatic step();
        bit       rv;
        bit       exp_rv;
        bit       exp_ov;
        int       due;
        exp_t     e;
        mem_req_t h;
        mem_req_t m;
        @(negedge clk);
        rst            = d_rst;
        redirect       = d_redirect;
        redirect_pc    = d_redirect_pc;
        out_ready      = d_out_ready;
        imem_req_ready = d_req_ready;
        rv = !d_rst && mem_q.size() > 0 && mem_q[0].due <= cyc;
        imem_resp_valid = rv;
        imem_resp_instr = rv ? mem_word(mem_q[0].addr_dut) : 32'h0;
        #1;
        s_req_valid = imem_req_valid;
        s_addr      = imem_req_addr;
        s_out_valid = out_valid;
        s_pc        = out_pc;
        s_instr     = out_instr;
        s_count     = 32'(queue_count);
        s_popped    = 1'b0;

        if (rst_prev) begin
            check("rst_req_valid", 32'(s_req_valid), 0);
            check("rst_req_addr",  s_addr, RESET_PC);
            check("rst_out_valid", 32'(s_out_valid), 0);
            check("rst_out_pc",    s_pc, 0);
            check("rst_out_instr", s_instr, 0);
            check("rst_count",     s_count, 0);
        end

        if (!d_rst) begin
            exp_rv = armed && !d_redirect && mem_q.size() < MAX_OUT
                  && (exp_q.size() + mem_q.size()) < DEPTH;
            exp_ov = exp_q.size() != 0 && !d_redirect;
            check("req_valid", 32'(s_req_valid), 32'(exp_rv));
            if (exp_rv) check("req_addr", s_addr, m_fetch_pc);
            check("out_valid", 32'(s_out_valid), 32'(exp_ov));
            check("queue_count", s_count, exp_q.size());
            if (exp_ov) begin
                check("out_pc", s_pc, exp_q[0].pc);
                check("out_instr", s_instr, exp_q[0].instr);
            end

            if (exp_ov && d_out_ready) begin
                e = exp_q.pop_front();
                s_popped    = 1'b1;
                s_pop_pc    = s_pc;
                s_pop_instr = s_instr;
            end
            if (rv) begin
                h = mem_q.pop_front();
                if (h.epoch == epoch && !d_redirect) begin
                    e.pc    = h.addr_exp;
                    e.instr = mem_word(h.addr_exp);
                    exp_q.push_back(e);
                end
            end
            if (s_req_valid === 1'b1 && d_req_ready) begin
                due = cyc + lat;
                if (due <= last_due) due = last_due + 1;
                last_due   = due;
                m.addr_dut = s_addr;
                m.addr_exp = m_fetch_pc;
                m.epoch    = epoch;
                m.due      = due;
                mem_q.push_back(m);
                m_fetch_pc = m_fetch_pc + 32'd1;
            end
            if (d_redirect) begin
                exp_q.delete();
                epoch++;
                m_fetch_pc = d_redirect_pc;
            end
            armed = 1'b1;
        end else begin
            mem_q.delete();
            exp_q.delete();
            m_fetch_pc = RESET_PC;
            armed      = 1'b0;
            last_due   = 0;
            epoch++;
        end
        rst_prev = d_rst;
        cyc++;
    endtask

    task automatic wait_pop(input string name, input logic [31:0] exp_pc);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            step();
            if (s_popped) found = 1'b1;
        end
        check({name, "_seen"}, 32'(found), 1);
        if (found) begin
            check({name, "_pc"}, s_pop_pc, exp_pc);
            check({name, "_instr"}, s_pop_instr, mem_word(exp_pc));
        end
    endtask

    task automatic redirect_to(input logic [31:0] pc);
        d_redirect    = 1'b1;
        d_redirect_pc = pc;
        step();
        d_redirect    = 1'b0;
    endtask

    initial begin
        bit found;

        // Reset, then continuous ready with one-cycle memory latency.
        //            chk rst rdy  rv  addr  ov  pc cnt
        vecs[0] = '{1'b0, 1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 0};
        vecs[1] = '{1'b1, 1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 0};
        vecs[2] = '{1'b1, 1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 0};
        vecs[3] = '{1'b1, 1'b0, 1'b1, 1'b1, 32'd0, 1'b0, 32'd0, 0};
        vecs[4] = '{1'b1, 1'b0, 1'b1, 1'b1, 32'd1, 1'b0, 32'd0, 0};
        vecs[5] = '{1'b1, 1'b0, 1'b1, 1'b1, 32'd2, 1'b1, 32'd0, 1};
        vecs[6] = '{1'b1, 1'b0, 1'b1, 1'b1, 32'd3, 1'b1, 32'd1, 1};
        vecs[7] = '{1'b1, 1'b0, 1'b1, 1'b1, 32'd4, 1'b1, 32'd2, 1};
        vecs[8] = '{1'b1, 1'b0, 1'b1, 1'b1, 32'd5, 1'b1, 32'd3, 1};

        lat         = 1;
        d_req_ready = 1'b1;
        d_redirect  = 1'b0;
        for (int i = 0; i < 9; i++) begin
            d_rst       = vecs[i].rst;
            d_out_ready = vecs[i].out_ready;
            step();
            if (vecs[i].chk) begin
                check("vec_req_valid", 32'(s_req_valid), 32'(vecs[i].exp_req_valid));
                if (vecs[i].exp_req_valid) check("vec_req_addr", s_addr, vecs[i].exp_addr);
                check("vec_out_valid", 32'(s_out_valid), 32'(vecs[i].exp_out_valid));
                check("vec_count", s_count, vecs[i].exp_count);
                if (vecs[i].exp_out_valid) begin
                    check("vec_out_pc", s_pc, vecs[i].exp_out_pc);
                    check("vec_out_instr", s_instr, mem_word(vecs[i].exp_out_pc));
                end
            end
        end

        // IF/ID stalled for 10 cycles: queue fills, requests stop, nothing lost.
        d_out_ready = 1'b0;
        repeat (10) step();
        check("stall_count", s_count, DEPTH);
        check("stall_req_valid", 32'(s_req_valid), 0);
        d_out_ready = 1'b1;
        repeat (12) step();

        // Redirect to 0x40 with two requests outstanding at latency 3.
        lat   = 3;
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            step();
            if (mem_q.size() == MAX_OUT) found = 1'b1;
        end
        check("two_outstanding_seen", 32'(found), 1);
        redirect_to(32'h40);
        step();
        check("redir40_count_after", s_count, 0);
        check("redir40_out_valid_after", 32'(s_out_valid), 0);
        wait_pop("redir40_first", 32'h40);
        repeat (6) step();

        // Redirect landing on a response cycle while IF/ID is ready.
        lat   = 1;
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            if (mem_q.size() > 0 && mem_q[0].due <= cyc && exp_q.size() > 0) found = 1'b1;
            else step();
        end
        check("coinc_setup_seen", 32'(found), 1);
        redirect_to(32'h80);
        check("coinc_no_pop", 32'(s_popped), 0);
        step();
        check("coinc_count_after", s_count, 0);
        wait_pop("coinc_first", 32'h80);

        // Back-to-back redirects: only the second stream may reach IF/ID.
        lat = 2;
        redirect_to(32'h10);
        redirect_to(32'h20);
        wait_pop("b2b_first", 32'h20);
        repeat (6) step();

        // Reset mid-stream with the queue full.
        lat         = 1;
        d_out_ready = 1'b0;
        repeat (12) step();
        check("full_before_rst", s_count, DEPTH);
        d_rst = 1'b1;
        step();
        d_rst = 1'b0;
        step();
        check("midrst_count", s_count, 0);
        check("midrst_out_pc", s_pc, 0);
        check("midrst_req_addr", s_addr, RESET_PC);
        step();
        check("midrst_restart_valid", 32'(s_req_valid), 1);
        check("midrst_restart_addr", s_addr, RESET_PC);
        d_out_ready = 1'b1;
        wait_pop("midrst_first", RESET_PC);

        // Randomized traffic, latency, stalls, redirects and occasional resets.
        for (int i = 0; i < 4000; i++) begin
            d_out_ready = ($urandom_range(0, 3) != 0);
            d_req_ready = ($urandom_range(0, 3) != 0);
            lat         = $urandom_range(1, 4);
            d_redirect  = ($urandom_range(0, 24) == 0);
            d_redirect_pc = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFE
                                                        : 32'($urandom_range(0, 255));
            d_rst       = ($urandom_range(0, 499) == 0);
            step();
        end
        d_rst      = 1'b0;
        d_redirect = 1'b0;
        repeat (20) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
